dense_layer_mac: RTL



---
 rtl/dense_pkg.sv | 19 +
 rtl/dense_requant.sv | 39 +++
 rtl/dense_layer_mac.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dense_pkg.sv
// Shared types and sizing helpers for the dense_layer_mac slice.
// Sizing is derived from the vector geometry so ports and accumulator stay consistent.
package dense_pkg;

  typedef enum logic [1:0] {
    LOAD,
    MAC,
    RESULT
  } state_t;

  function automatic int acc_width(input int dw, input int n_in);
    return 2 * dw + $clog2(n_in) + 1;
  endfunction

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_requant.sv
// Combinational requantiser: arithmetic shift, saturation to OUT_W, optional ReLU (DENSE_RELU_EN).
// No state; the caller registers the result.
module dense_requant #(
  parameter int ACC_W = 21,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] res
);

  logic signed [ACC_W-1:0] shifted;
  logic signed [OUT_W-1:0] sat;

  assign shifted = acc >>> SHIFT;

  generate
    if (ACC_W > OUT_W) begin : g_sat
      // The value fits only if every bit above the output sign bit copies it.
      logic [ACC_W-OUT_W:0] hi;
      assign hi = shifted[ACC_W-1:OUT_W-1];
      always_comb begin
        sat = shifted[OUT_W-1:0];
        if (!((&hi) || !(|hi))) begin
          sat = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
    end else begin : g_ext
      assign sat = OUT_W'(shifted);
    end
  endgenerate

`ifdef DENSE_RELU_EN
  assign res = sat[OUT_W-1] ? '0 : sat;
`else
  assign res = sat;
`endif

endmodule

// File: rtl/dense_layer_mac.sv
// Time-multiplexed dense layer: buffer N_IN activations, then one neuron per N_IN+2 cycles.
// Result held under out_ready backpressure; input stalls outside LOAD. DENSE_RELU_EN adds ReLU.
module dense_layer_mac
  import dense_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int N_OUT = 4,
  parameter int DW    = 8,
  parameter int BW    = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [DW-1:0]                   in_data,
  output logic        [addr_width(N_IN*N_OUT)-1:0] w_addr,
  input  logic signed [DW-1:0]                   w_data,
  output logic        [addr_width(N_OUT)-1:0]    b_addr,
  input  logic signed [BW-1:0]                   b_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [OUT_W-1:0]                out_data,
  output logic                                   out_last
);

  localparam int ACC_W = acc_width(DW, N_IN);
  localparam int AW    = addr_width(N_IN * N_OUT);
  localparam int OW    = addr_width(N_OUT);
  localparam int CW    = $clog2(N_IN + 1);
  localparam logic [AW-1:0] N_IN_A = AW'(N_IN);

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [OW-1:0] o;
  logic signed [DW-1:0] act [N_IN];
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [2*DW-1:0] prod;
  logic signed [OUT_W-1:0] res;
  logic last_beat, mac_done, neuron_last, out_hs;

  assign in_ready    = (state == LOAD);
  assign last_beat   = (state == LOAD) && in_valid && (cnt == CW'(N_IN - 1));
  assign mac_done    = (state == MAC) && (cnt == CW'(N_IN));
  assign neuron_last = (o == OW'(N_OUT - 1));
  assign out_hs      = (state == RESULT) && out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (last_beat) state_nxt = MAC;
      MAC:     if (mac_done) state_nxt = RESULT;
      RESULT:  if (out_hs) state_nxt = neuron_last ? LOAD : MAC;
      default: state_nxt = LOAD;
    endcase
  end

  // Address is issued on cnt 0..N_IN-1; the ROM answers one cycle later.
  always_comb begin
    w_addr = AW'(o) * N_IN_A;
    if (state == MAC && cnt < CW'(N_IN)) w_addr = AW'(o) * N_IN_A + AW'(cnt);
  end
  assign b_addr = o;

  assign prod    = act[0] * w_data;
  assign acc_nxt = ((cnt == CW'(1)) ? ACC_W'(b_data) : acc) + ACC_W'(prod);

  dense_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc (acc_nxt),
    .res (res)
  );

  // Buffer rotates once per product, so it is back in order after each neuron.
  always_ff @(posedge clk) begin
    if ((state == LOAD && in_valid) || (state == MAC && cnt != '0)) begin
      for (int i = 0; i < N_IN - 1; i++) act[i] <= act[i+1];
      act[N_IN-1] <= (state == LOAD) ? in_data : act[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      o         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) cnt <= last_beat ? '0 : cnt + 1'b1;
        end
        MAC: begin
          cnt <= cnt + 1'b1;
          if (cnt != '0) acc <= acc_nxt;
          if (mac_done) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            out_data  <= res;
            out_last  <= neuron_last;
          end
        end
        RESULT: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            o         <= neuron_last ? '0 : o + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
